chan_err_injector: RTL

Parametrised channel error injector placed between the convolutional encoder output and the Viterbi decoder input in the tx/rx datapath. Corrupts encoded symbols under one of several selectable modes (periodic burst, pseudo-random, pass-through) with a programmable XOR mask, and keeps word and error statistics for bit-error-rate checks. It is the next generation of the fixed single-mode burst injector: symbol width, burst period and length, and window are configurable, and a runtime mode select and a random mode are added.

---
 rtl/chan_err_pkg.sv | 24 ++
 rtl/chan_err_injector_lfsr16.sv | 21 ++
 rtl/chan_err_injector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
// Holds mode/FSM enums, the LFSR tap mask and its feedback helper.
package chan_err_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BURST = 2'd1,
    MODE_RAND  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/chan_err_injector_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left once per enabled cycle.
// Ports: clk, rst (sync, high), seed, adv (shift enable), state.
module lfsr16
  import chan_err_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (adv) begin
      state <= {state[14:0], lfsr_fb(state)};
    end
  end

endmodule

// File: rtl/chan_err_injector.sv
// Channel error injector between encoder output and Viterbi input.
// Ports: clk/rst, mode/mask/threshold controls, valid_i/d_i in,
// valid_o/d_o/inj_o out (1-cycle latency), burst_active_o, and
// saturating word / symbol-error / bit-error counters.
module chan_err_injector
  import chan_err_pkg::*;
#(
  parameter int          W           = 2,
  parameter int          PERIOD_LOG2 = 5,
  parameter int          BURST_LEN   = 3,
  parameter int          MAX_WORDS   = 256,
  parameter int          CNT_W       = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     err_mask_i,
  input  logic [7:0]       rand_thresh_i,
  input  logic             valid_i,
  input  logic [W-1:0]     d_i,
  output logic             valid_o,
  output logic [W-1:0]     d_o,
  output logic             inj_o,
  output logic             burst_active_o,
  output logic [CNT_W-1:0] word_ct_o,
  output logic [CNT_W-1:0] sym_err_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o
);

  localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PC_W = $clog2(W + 1);

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);
  localparam logic [CNT_W:0]  WIN     = (CNT_W + 1)'(MAX_WORDS);

  mode_e            mode;
  burst_state_e     state;
  logic [BC_W-1:0]  burst_cnt;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] word_ct;
  logic [CNT_W-1:0] sym_err_ct;
  logic [CNT_W-1:0] bit_err_ct;
  logic [PC_W-1:0]  ones;
  logic [CNT_W:0]   bit_sum;
  logic             in_win;
  logic             gate;
  logic             trig;
  logic             burst_hit;
  logic             rand_hit;
  logic             hit;

  assign mode = mode_e'(mode_i);

  // The LFSR runs on every accepted word regardless of mode so the
  // random pattern depends only on word position since reset.
  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .adv   (valid_i),
    .state (lfsr)
  );

  // word_ct is the index of the word currently being accepted.
  assign in_win = {1'b0, word_ct} < WIN;
  assign gate   = in_win && (err_mask_i != '0);
  assign trig   = &word_ct[PERIOD_LOG2-1:0];

  assign burst_hit = (mode == MODE_BURST) && (state == BURST);
  assign rand_hit  = (mode == MODE_RAND) &&
                     ((lfsr & 16'h00FF) < 16'(rand_thresh_i));
  assign hit       = gate && (burst_hit || rand_hit);

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + PC_W'(err_mask_i[i]);
    end
  end

  assign bit_sum = {1'b0, bit_err_ct} + (CNT_W + 1)'(ones);

  // Periodic-burst FSM. The trigger word moves to BURST but is not
  // itself corrupted; retriggers inside a burst are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if (valid_i) begin
      if ((mode != MODE_BURST) || !in_win) begin
        state     <= IDLE;
        burst_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (trig) begin
              state     <= BURST;
              burst_cnt <= '0;
            end
          end
          BURST: begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BC_LAST) begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign burst_active_o = (state == BURST);

  // Output stage and statistics share one edge so counters always
  // describe the d_o presented alongside them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o    <= 1'b0;
      d_o        <= '0;
      inj_o      <= 1'b0;
      word_ct    <= '0;
      sym_err_ct <= '0;
      bit_err_ct <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        d_o   <= hit ? (d_i ^ err_mask_i) : d_i;
        inj_o <= hit;
        if (!(&word_ct)) begin
          word_ct <= word_ct + 1'b1;
        end
        if (hit) begin
          if (!(&sym_err_ct)) begin
            sym_err_ct <= sym_err_ct + 1'b1;
          end
          bit_err_ct <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        end
      end else begin
        d_o   <= '0;
        inj_o <= 1'b0;
      end
    end
  end

  assign word_ct_o    = word_ct;
  assign sym_err_ct_o = sym_err_ct;
  assign bit_err_ct_o = bit_err_ct;

endmodule
